// File: rtl/ins_cache_ctrl.sv
// Direct-mapped 8-line instruction cache controller with a 128-bit block refill from instruction memory.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module ins_cache_ctrl #(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned BLOCK_BITS = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic [9:0]            address,
    output logic [31:0]           instruction,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [5:0]            mem_address,
    input  logic [BLOCK_BITS-1:0] mem_readinstruction,
`ifdef ICACHE_STATS_EN
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count,
`endif
    input  logic                  mem_busywait
);

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t                state, state_next;
    logic [BLOCK_BITS-1:0] data_mem [NUM_BLOCKS];
    logic [2:0]            tag_mem  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid;
    logic [5:0]            fill_addr;
    logic                  mem_armed;

    logic [2:0] tag;
    logic [2:0] index;
    logic [1:0] offset;
    logic       line_valid;
    logic       hit;
    logic       unused_byte_bits;

    assign tag              = address[9:7];
    assign index            = address[6:4];
    assign offset           = address[3:2];
    assign unused_byte_bits = &{1'b0, address[1:0]};

    assign line_valid  = valid[index];
    assign hit         = read & line_valid & (tag_mem[index] == tag);
    assign instruction = line_valid ? data_mem[index][{offset, 5'b0} +: 32] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            valid     <= '0;
            fill_addr <= '0;
            mem_armed <= 1'b0;
        end else begin
            state     <= state_next;
            // mem_busywait is only trusted after one full cycle in MEM_READ
            mem_armed <= (state == MEM_READ);
            if (state == IDLE && state_next == MEM_READ)
                fill_addr <= address[9:4];
            if (state == UPDATE)
                valid[fill_addr[2:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (state == UPDATE) begin
            data_mem[fill_addr[2:0]] <= mem_readinstruction;
            tag_mem[fill_addr[2:0]]  <= fill_addr[5:3];
        end
    end

    always_comb begin
        state_next  = state;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        // outputs forced idle while reset is held, even with read asserted
        if (reset) begin
            case (state)
                IDLE: begin
                    if (read && !hit) begin
                        busywait   = 1'b1;
                        state_next = MEM_READ;
                    end
                end
                MEM_READ: begin
                    busywait    = 1'b1;
                    mem_read    = 1'b1;
                    mem_address = fill_addr;
                    if (mem_armed && !mem_busywait)
                        state_next = UPDATE;
                end
                UPDATE: begin
                    busywait   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && hit && hit_count != '1)
                hit_count <= hit_count + 16'd1;
            if (state == IDLE && state_next == MEM_READ && miss_count != '1)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ins_cache_ctrl.sv
// Directed testbench for ins_cache_ctrl with a behavioural block memory of fixed latency.
// Counter checks are compiled in when ICACHE_STATS_EN is defined.
module tb_ins_cache_ctrl;

    localparam int unsigned LAT = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinstruction;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned lat;

    ins_cache_ctrl #(.NUM_BLOCKS(8), .BLOCK_BITS(128)) dut (
        .clock               (clock),
        .reset               (reset),
        .read                (read),
        .address             (address),
        .instruction         (instruction),
        .busywait            (busywait),
        .mem_read            (mem_read),
        .mem_address         (mem_address),
        .mem_readinstruction (mem_readinstruction),
`ifdef ICACHE_STATS_EN
        .hit_count           (hit_count),
        .miss_count          (miss_count),
`endif
        .mem_busywait        (mem_busywait)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] n);
        return 32'hC0DE_0000 | {18'd0, blk, 6'd0, n};
    endfunction

    // Memory: busy for LAT cycles after mem_read is seen, then presents the block and holds it
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_busywait        <= 1'b0;
            lat                 <= 0;
            mem_readinstruction <= '0;
        end else if (mem_read) begin
            if (lat < LAT) begin
                mem_busywait <= 1'b1;
                lat          <= lat + 1;
            end else begin
                mem_busywait <= 1'b0;
                for (int n = 0; n < 4; n++)
                    mem_readinstruction[32*n +: 32] <= mem_word(mem_address, 2'(n));
            end
        end else begin
            mem_busywait <= 1'b0;
            lat          <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [9:0] a, input logic exp_miss, input string nm);
        int unsigned n;
        @(negedge clock);
        read    = 1'b1;
        address = a;
        #1;
        check({nm, " busywait"}, {31'd0, busywait}, {31'd0, exp_miss});
        if (exp_miss) begin
            @(posedge clock); #1;
            check({nm, " mem_read"}, {31'd0, mem_read}, 32'd1);
            check({nm, " mem_address"}, {26'd0, mem_address}, {26'd0, a[9:4]});
            n = 0;
            while (busywait && n < 100) begin
                @(posedge clock); #1;
                n++;
            end
            check({nm, " fill timeout"}, {31'd0, (n < 100)}, 32'd1);
        end
        check({nm, " instruction"}, instruction, mem_word(a[9:4], a[3:2]));
        if (exp_miss)
            @(posedge clock);
    endtask

    initial begin
        reset   = 1'b0;
        read    = 1'b1;
        address = 10'h000;
        #12;
        check("rst busywait", {31'd0, busywait}, 32'd0);
        check("rst mem_read", {31'd0, mem_read}, 32'd0);
        check("rst mem_address", {26'd0, mem_address}, 32'd0);
        check("rst instruction", instruction, 32'd0);
        @(negedge clock);
        read  = 1'b0;
        reset = 1'b1;

        fetch(10'h000, 1'b1, "cold");
        fetch(10'h004, 1'b0, "hit w1");
        fetch(10'h008, 1'b0, "hit w2");
        fetch(10'h00C, 1'b0, "hit w3");
        @(negedge clock);
        read = 1'b0;
`ifdef ICACHE_STATS_EN
        check("stats miss", {16'd0, miss_count}, 32'd1);
        check("stats hit", {16'd0, hit_count}, 32'd4);
`endif

        fetch(10'h080, 1'b1, "conflict");
        fetch(10'h084, 1'b0, "conflict w1");
        fetch(10'h000, 1'b1, "evicted");

        for (int i = 1; i < 8; i++)
            fetch(10'(i * 16), 1'b1, $sformatf("spread miss %0d", i));
        for (int i = 1; i < 8; i++)
            fetch(10'(i * 16 + 12), 1'b0, $sformatf("spread hit %0d", i));

        // read dropped mid-fill: line still installed
        @(negedge clock);
        read    = 1'b1;
        address = 10'h0A8;
        @(posedge clock); #1;
        check("drop mem_read", {31'd0, mem_read}, 32'd1);
        @(negedge clock);
        read = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("drop busywait", {31'd0, busywait}, 32'd0);
        fetch(10'h0A8, 1'b0, "drop replay");

        // reset during MEM_READ
        @(negedge clock);
        read    = 1'b1;
        address = 10'h3F0;
        @(posedge clock); #1;
        check("midrst mem_read pre", {31'd0, mem_read}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst mem_read", {31'd0, mem_read}, 32'd0);
        check("midrst busywait", {31'd0, busywait}, 32'd0);
        check("midrst instruction", instruction, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        read  = 1'b0;
        fetch(10'h000, 1'b1, "post rst");
        fetch(10'h3F0, 1'b1, "post rst discard");

`ifdef ICACHE_STATS_EN
        @(negedge clock);
        read    = 1'b1;
        address = 10'h004;
        repeat (65540) @(posedge clock);
        #1;
        check("hit saturate", {16'd0, hit_count}, 32'h0000_FFFF);
        @(negedge clock);
        read = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
